// File: rtl/unit_delete_sched.sv
// Unit-literal scheduler: issues pending variables lowest-index first over valid/ready
// and flags opposite-polarity units on the same variable.
//   state | meaning
//   IDLE  | nothing pending, slot empty
//   RUN   | pending work or slot occupied
//   CONFL | conflict seen, everything frozen until flush
module unit_delete_sched #(
    parameter int W     = 8,
    parameter int IDX_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ld_en,
    input  logic [W-1:0]     ld_mask,
    input  logic [W-1:0]     ld_pol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_var,
    output logic             out_pol,
    output logic [W-1:0]     pending,
    output logic             busy,
    output logic             conflict,
    output logic [IDX_W-1:0] conflict_var
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CONFL = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     pol, pol_nxt, pending_nxt, sel_clear, confl_mask;
    logic [IDX_W-1:0] sel_idx, confl_idx, out_var_nxt, conflict_var_nxt;
    logic             out_valid_nxt, out_pol_nxt, conflict_nxt;
    logic             fire, slot_free, any_confl;

    // A load conflicts with a stored unit whether it still sits in pending or in the slot.
    always_comb begin
        confl_mask = '0;
        for (int i = 0; i < W; i++) begin
            confl_mask[i] = ld_mask[i] &&
                ((pending[i] && (pol[i] != ld_pol[i])) ||
                 (out_valid && (out_var == IDX_W'(i)) && (out_pol != ld_pol[i])));
        end
    end

    always_comb begin
        sel_idx   = '0;
        confl_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (pending[i])    sel_idx   = IDX_W'(i);
            if (confl_mask[i]) confl_idx = IDX_W'(i);
        end
    end

    assign fire      = out_valid & out_ready;
    assign slot_free = !out_valid || fire;
    assign any_confl = ld_en && (|confl_mask);
    assign busy      = (|pending) || out_valid;

    always_comb begin
        state_nxt        = state;
        pending_nxt      = pending;
        pol_nxt          = pol;
        out_valid_nxt    = out_valid;
        out_var_nxt      = out_var;
        out_pol_nxt      = out_pol;
        conflict_nxt     = conflict;
        conflict_var_nxt = conflict_var;
        sel_clear        = '0;

        if (flush) begin
            state_nxt        = IDLE;
            pending_nxt      = '0;
            pol_nxt          = '0;
            out_valid_nxt    = 1'b0;
            out_var_nxt      = '0;
            out_pol_nxt      = 1'b0;
            conflict_nxt     = 1'b0;
            conflict_var_nxt = '0;
        end else if (state == CONFL) begin
            state_nxt = CONFL;
        end else if (any_confl) begin
            // pending and pol stay as they were so the conflict can be inspected
            state_nxt        = CONFL;
            conflict_nxt     = 1'b1;
            conflict_var_nxt = confl_idx;
            out_valid_nxt    = 1'b0;
        end else begin
            if (slot_free) begin
                if (|pending) begin
                    sel_clear     = W'(1) << sel_idx;
                    out_valid_nxt = 1'b1;
                    out_var_nxt   = sel_idx;
                    out_pol_nxt   = pol[sel_idx];
                end else begin
                    out_valid_nxt = 1'b0;
                end
            end
            pending_nxt = (pending & ~sel_clear) | (ld_en ? ld_mask : '0);
            if (ld_en) pol_nxt = (pol & ~ld_mask) | (ld_pol & ld_mask);
            state_nxt = ((|pending_nxt) || out_valid_nxt) ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            pol          <= '0;
            out_valid    <= 1'b0;
            out_var      <= '0;
            out_pol      <= 1'b0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            pol          <= pol_nxt;
            out_valid    <= out_valid_nxt;
            out_var      <= out_var_nxt;
            out_pol      <= out_pol_nxt;
            conflict     <= conflict_nxt;
            conflict_var <= conflict_var_nxt;
        end
    end

endmodule

// File: tb/tb_unit_delete_sched.sv
// Directed and randomized checks of unit_delete_sched against a set-based reference model.
module tb_unit_delete_sched;

    logic       clk = 1'b0;
    logic       rst, flush, ld_en, out_ready;
    logic [7:0] ld_mask, ld_pol;
    logic       out_valid, out_pol, busy, conflict;
    logic [2:0] out_var, conflict_var;
    logic [7:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending set, polarity table, issue slot, conflict flag
    bit [7:0] m_pend, m_pol;
    bit       m_valid, m_opol, m_conf;
    bit [2:0] m_var, m_cvar;

    always #5 clk = ~clk;

    unit_delete_sched #(.W(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ld_en(ld_en),
        .ld_mask(ld_mask), .ld_pol(ld_pol),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_var(out_var), .out_pol(out_pol),
        .pending(pending), .busy(busy),
        .conflict(conflict), .conflict_var(conflict_var)
    );

    function automatic bit [2:0] lowest(input bit [7:0] x);
        int n = 0;
        while (n < 7 && !x[n]) n++;
        return 3'(n);
    endfunction

    function automatic void model_reset();
        m_pend = '0; m_pol = '0; m_valid = 0; m_opol = 0;
        m_conf = 0;  m_var = '0; m_cvar = '0;
    endfunction

    function automatic void model_step();
        bit [7:0] clash = '0;
        bit [7:0] p;
        if (flush) begin
            model_reset();
            return;
        end
        if (m_conf) return;
        if (ld_en) begin
            for (int i = 0; i < 8; i++) begin
                bit held_pend = m_pend[i] && (m_pol[i] != ld_pol[i]);
                bit held_slot = m_valid && (int'(m_var) == i) && (m_opol != ld_pol[i]);
                if (ld_mask[i] && (held_pend || held_slot)) clash[i] = 1'b1;
            end
        end
        if (clash != 0) begin
            m_conf  = 1;
            m_cvar  = lowest(clash);
            m_valid = 0;
            return;
        end
        p = m_pend;
        if (!m_valid || out_ready) begin
            if (p != 0) begin
                m_var   = lowest(p);
                m_opol  = m_pol[m_var];
                m_valid = 1;
                p[m_var] = 1'b0;
            end else begin
                m_valid = 0;
            end
        end
        if (ld_en) begin
            p     = p | ld_mask;
            m_pol = (m_pol & ~ld_mask) | (ld_pol & ld_mask);
        end
        m_pend = p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},    8'(out_valid), 8'(m_valid));
        if (m_valid) begin
            chk({tag, ".var"},  8'(out_var),   8'(m_var));
            chk({tag, ".pol"},  8'(out_pol),   8'(m_opol));
        end
        chk({tag, ".pending"},  pending,        m_pend);
        chk({tag, ".busy"},     8'(busy),      8'((m_pend != 0) || m_valid));
        chk({tag, ".conflict"}, 8'(conflict),  8'(m_conf));
        chk({tag, ".cvar"},     8'(conflict_var), 8'(m_cvar));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic load(input logic [7:0] mask, input logic [7:0] pol);
        ld_en = 1'b1; ld_mask = mask; ld_pol = pol;
    endtask

    task automatic idle_in();
        ld_en = 1'b0; ld_mask = '0; ld_pol = '0; flush = 1'b0;
    endtask

    task automatic do_flush();
        idle_in();
        flush = 1'b1;
        tick("flush");
        flush = 1'b0;
    endtask

    initial begin
        bit [2:0] seq1 [4];
        seq1[0] = 3'd2; seq1[1] = 3'd4; seq1[2] = 3'd5; seq1[3] = 3'd7;

        rst = 1'b1; idle_in(); out_ready = 1'b0;
        model_reset();
        #3;
        check_model("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: scattered mask issues 2,4,5,7 back to back
        out_ready = 1'b1;
        load(8'b1011_0100, 8'hFF);
        tick("t1.load");
        chk("t1.valid_after_load", 8'(out_valid), 8'd0);
        idle_in();
        for (int k = 0; k < 4; k++) begin
            tick("t1.issue");
            chk("t1.seq_var", 8'(out_var), 8'(seq1[k]));
            chk("t1.seq_pol", 8'(out_pol), 8'd1);
        end
        tick("t1.drain");
        chk("t1.end_valid", 8'(out_valid), 8'd0);
        chk("t1.end_busy",  8'(busy),      8'd0);

        // 2: stall holds var 0, then 0 and 7 issue
        out_ready = 1'b0;
        load(8'h81, 8'h00);
        tick("t2.load");
        idle_in();
        for (int k = 0; k < 5; k++) begin
            tick("t2.stall");
            chk("t2.hold_var",  8'(out_var), 8'd0);
            chk("t2.hold_pend", pending,     8'h80);
        end
        out_ready = 1'b1;
        tick("t2.fire0");
        chk("t2.second_var", 8'(out_var), 8'd7);
        tick("t2.fire7");
        chk("t2.end_valid", 8'(out_valid), 8'd0);

        // 3: polarity clash on a pending bit
        out_ready = 1'b0;
        load(8'h09, 8'hFF);
        tick("t3.load");
        idle_in();
        tick("t3.slot0");
        load(8'h08, 8'h00);
        tick("t3.clash");
        chk("t3.conflict", 8'(conflict),     8'd1);
        chk("t3.cvar",     8'(conflict_var), 8'd3);
        chk("t3.valid",    8'(out_valid),    8'd0);
        out_ready = 1'b1;
        load(8'hF0, 8'hF0);
        tick("t3.ignored");
        chk("t3.frozen_pend", pending, 8'h08);
        do_flush();
        chk("t3.flush_pend", pending,      8'h00);
        chk("t3.flush_conf", 8'(conflict), 8'd0);

        // 4: same-polarity duplicate vs. opposite polarity on the slot variable
        out_ready = 1'b0;
        load(8'h02, 8'h00);
        tick("t4.load");
        idle_in();
        tick("t4.slot1");
        load(8'h02, 8'h00);
        tick("t4.dup");
        chk("t4.no_conflict", 8'(conflict), 8'd0);
        load(8'h02, 8'h02);
        tick("t4.clash");
        chk("t4.conflict", 8'(conflict),     8'd1);
        chk("t4.cvar",     8'(conflict_var), 8'd1);
        do_flush();

        // 5: reload during refill issues var 0 twice
        out_ready = 1'b1;
        load(8'h01, 8'h01);
        tick("t5.load");
        load(8'h01, 8'h01);
        tick("t5.refill_reload");
        chk("t5.first_valid", 8'(out_valid), 8'd1);
        chk("t5.repended",    pending,       8'h01);
        idle_in();
        tick("t5.second");
        chk("t5.second_valid", 8'(out_valid), 8'd1);
        chk("t5.second_var",   8'(out_var),   8'd0);
        tick("t5.drain");

        // 6: async reset mid-handshake, then flush beats a load
        out_ready = 1'b0;
        load(8'h01, 8'h00);
        tick("t6.load");
        idle_in();
        tick("t6.valid");
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6.rst_valid", 8'(out_valid), 8'd0);
        check_model("t6.rst");
        #1;
        rst = 1'b0;
        load(8'hFF, 8'hAA);
        flush = 1'b1;
        tick("t6.flush_ld");
        chk("t6.flush_pend", pending, 8'h00);
        idle_in();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            ld_en     = ($urandom_range(0, 2) == 0);
            ld_mask   = 8'($urandom);
            ld_pol    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_pol;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = m_conf ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            tick("rand");
        end
        idle_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
